// File: rtl/sdram_ctrl_init_ref_if.sv
// Command-bus handshake between the init/refresh sequencer and the access
// engine's command mux: request/grant plus the command and address it drives.
interface sdram_ctrl_init_ref_if;
  logic        req;
  logic        gnt;
  logic [3:0]  cmd;
  logic [12:0] cmd_addr;

  modport master (output req, output cmd, output cmd_addr, input gnt);
  modport slave  (input req, input cmd, input cmd_addr, output gnt);
endinterface

// File: rtl/sdram_ctrl_init_ref.sv
// SDRAM power-up init sequencer (PRECHARGE ALL, 2x AUTO REFRESH, LOAD MODE)
// and periodic refresh timer, issuing commands whenever the bus is granted.
module sdram_ctrl_init_ref #(
  parameter int INIT_WAIT = 20000,
  parameter int T_MRD     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_en,
  input  logic [2:0]           cl,
  input  logic [2:0]           t_rp,
  input  logic [2:0]           t_ref,
  input  logic [12:0]          ref_count,
  sdram_ctrl_init_ref_if.master bus,
  output logic                 init_done,
  output logic                 ref_miss
);

  localparam int            PW        = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [PW-1:0] PWR_LAST  = PW'(INIT_WAIT - 1);
  localparam logic [7:0]    MRD_LEN   = (T_MRD > 1) ? 8'(T_MRD) : 8'd1;
  localparam logic [3:0]    CMD_NOP   = 4'b0111;
  localparam logic [3:0]    CMD_PRE   = 4'b0010;
  localparam logic [3:0]    CMD_AR    = 4'b0001;
  localparam logic [3:0]    CMD_LMR   = 4'b0000;
  localparam logic [12:0]   ADDR_PALL = 13'h0400;

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, PRE, PRE_W, AR1, AR1_W, AR2, AR2_W, MRS, MRS_W,
    RUN, R_PRE, R_PRE_W, R_AR, R_AR_W
  } state_t;

  state_t        state;
  logic [PW-1:0] pwr_cnt;
  logic [7:0]    wcnt;
  logic [12:0]   ivl;
  logic          pending;

  logic [7:0]    rp_len;
  logic [7:0]    rfc_len;
  logic [12:0]   mode_word;
  logic          wait_done;
  logic          run_phase;
  logic          expire;
  logic          refresh_done;

  assign rp_len       = (t_rp == 3'd0)  ? 8'd1 : {5'd0, t_rp};
  assign rfc_len      = (t_ref == 3'd0) ? 8'd1 : {5'd0, t_ref};
  assign mode_word    = {3'b000, 1'b0, 2'b00, cl, 1'b0, 3'b000};
  assign wait_done    = (wcnt <= 8'd1);
  assign run_phase    = state inside {RUN, R_PRE, R_PRE_W, R_AR, R_AR_W};
  assign expire       = run_phase && (ivl == 13'd1);
  assign refresh_done = (state == R_AR_W) && wait_done;

  // Dropping ctrl_en behaves exactly like reset so re-enabling reruns the whole init.
  always_ff @(posedge clk) begin
    if (!rst || !ctrl_en) begin
      state        <= IDLE;
      pwr_cnt      <= '0;
      wcnt         <= '0;
      ivl          <= '0;
      pending      <= 1'b0;
      bus.req      <= 1'b0;
      bus.cmd      <= CMD_NOP;
      bus.cmd_addr <= '0;
      init_done    <= 1'b0;
      ref_miss     <= 1'b0;
    end else begin
      bus.cmd      <= CMD_NOP;
      bus.cmd_addr <= '0;
      case (state)
        IDLE: begin
          pwr_cnt <= '0;
          bus.req <= 1'b1;
          state   <= PWR_WAIT;
        end
        PWR_WAIT: if (pwr_cnt == PWR_LAST) state <= PRE; else pwr_cnt <= pwr_cnt + 1'b1;
        PRE: if (bus.gnt) begin
          bus.cmd      <= CMD_PRE;
          bus.cmd_addr <= ADDR_PALL;
          wcnt         <= rp_len;
          state        <= PRE_W;
        end
        PRE_W: if (wait_done) state <= AR1; else wcnt <= wcnt - 8'd1;
        AR1: if (bus.gnt) begin
          bus.cmd <= CMD_AR;
          wcnt    <= rfc_len;
          state   <= AR1_W;
        end
        AR1_W: if (wait_done) state <= AR2; else wcnt <= wcnt - 8'd1;
        AR2: if (bus.gnt) begin
          bus.cmd <= CMD_AR;
          wcnt    <= rfc_len;
          state   <= AR2_W;
        end
        AR2_W: if (wait_done) state <= MRS; else wcnt <= wcnt - 8'd1;
        MRS: if (bus.gnt) begin
          bus.cmd      <= CMD_LMR;
          bus.cmd_addr <= mode_word;
          wcnt         <= MRD_LEN;
          state        <= MRS_W;
        end
        MRS_W: if (wait_done) begin
          init_done <= 1'b1;
          bus.req   <= 1'b0;
          ivl       <= ref_count;
          state     <= RUN;
        end else wcnt <= wcnt - 8'd1;
        RUN: if (pending) begin
          bus.req <= 1'b1;
          state   <= R_PRE;
        end
        R_PRE: if (bus.gnt) begin
          bus.cmd      <= CMD_PRE;
          bus.cmd_addr <= ADDR_PALL;
          wcnt         <= rp_len;
          state        <= R_PRE_W;
        end
        R_PRE_W: if (wait_done) state <= R_AR; else wcnt <= wcnt - 8'd1;
        R_AR: if (bus.gnt) begin
          bus.cmd <= CMD_AR;
          wcnt    <= rfc_len;
          state   <= R_AR_W;
        end
        R_AR_W: if (wait_done) begin
          pending <= 1'b0;
          bus.req <= 1'b0;
          state   <= RUN;
        end else wcnt <= wcnt - 8'd1;
        default: state <= IDLE;
      endcase

      // Interval timer runs through refresh sequences; an expiry on the edge a
      // refresh completes queues a fresh refresh rather than counting as a miss.
      if (run_phase) begin
        if (expire) begin
          ivl     <= ref_count;
          pending <= 1'b1;
          if (pending && !refresh_done) ref_miss <= 1'b1;
        end else if (ivl != 13'd0) begin
          ivl <= ivl - 13'd1;
        end else begin
          ivl <= ref_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_ctrl_init_ref.sv
// Bench for sdram_ctrl_init_ref: a command-list reference model checked every
// cycle, a table of init timing vectors, and hand-written refresh corner cases.
module tb_sdram_ctrl_init_ref;

  localparam int         INIT_WAIT = 10;
  localparam int         T_MRD     = 2;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, AR = 4'b0001, LMR = 4'b0000;

  logic        clk;
  logic        rst;
  logic        ctrl_en;
  logic [2:0]  cl;
  logic [2:0]  t_rp;
  logic [2:0]  t_ref;
  logic [12:0] ref_count;
  logic        init_done;
  logic        ref_miss;

  sdram_ctrl_init_ref_if bus ();

  sdram_ctrl_init_ref #(.INIT_WAIT(INIT_WAIT), .T_MRD(T_MRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_en   (ctrl_en),
    .cl        (cl),
    .t_rp      (t_rp),
    .t_ref     (t_ref),
    .ref_count (ref_count),
    .bus       (bus),
    .init_done (init_done),
    .ref_miss  (ref_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a phase, a list of commands still to issue, and an
  // absolute cycle stamp for the next refresh expiry.
  int         m_mode = 0;
  int         m_pwr  = 0;
  logic [3:0] m_seq[$];
  bit         m_init = 1'b0;
  bit         m_gwait = 1'b0;
  int         m_wait = 0;
  bit         m_pend = 1'b0;
  bit         m_tmr_on = 1'b0;
  int         m_next = 0;
  logic        e_req, e_done, e_miss;
  logic [3:0]  e_cmd;
  logic [12:0] e_addr;

  typedef struct {
    logic [2:0]  rp, rf, c;
    int          exp_first, exp_pre_ar, exp_ar_ar, exp_ar_mrs, exp_done_lat;
    logic [12:0] exp_mode_addr;
  } init_vec_t;

  init_vec_t vecs[4];

  function automatic int max1(input logic [2:0] v);
    return (v == 3'd0) ? 1 : int'(v);
  endfunction

  task automatic model_edge();
    bit active, old_pend, fin;
    logic [3:0] c;
    cyc++;
    if (!rst || !ctrl_en) begin
      m_mode = 0; m_pend = 1'b0; m_seq.delete();
      e_req = 1'b0; e_cmd = NOP; e_addr = '0; e_done = 1'b0; e_miss = 1'b0;
      return;
    end
    active   = (m_mode == 3) || (m_mode == 2 && !m_init);
    old_pend = m_pend;
    fin      = 1'b0;
    e_cmd    = NOP;
    e_addr   = '0;
    case (m_mode)
      0: begin m_mode = 1; m_pwr = 0; e_req = 1'b1; end
      1: if (m_pwr == INIT_WAIT - 1) begin
           m_mode = 2; m_init = 1'b1; m_seq = '{PRE, AR, AR, LMR}; m_gwait = 1'b1;
         end else m_pwr++;
      2: if (m_gwait) begin
           if (bus.gnt) begin
             c = m_seq.pop_front();
             e_cmd  = c;
             e_addr = (c == PRE) ? 13'h0400 : (c == LMR) ? {6'b0, cl, 4'b0} : 13'h0;
             m_wait = (c == PRE) ? max1(t_rp) : (c == AR) ? max1(t_ref) : T_MRD;
             m_gwait = 1'b0;
           end
         end else if (m_wait > 1) m_wait--;
         else if (m_seq.size() != 0) m_gwait = 1'b1;
         else begin
           m_mode = 3; e_req = 1'b0;
           if (m_init) begin
             e_done = 1'b1; m_tmr_on = (ref_count != 0); m_next = cyc + int'(ref_count);
           end else begin
             m_pend = 1'b0; fin = 1'b1;
           end
         end
      3: if (m_pend) begin
           m_mode = 2; m_init = 1'b0; m_seq = '{PRE, AR}; m_gwait = 1'b1; e_req = 1'b1;
         end
      default: m_mode = 0;
    endcase
    if (active) begin
      if (!m_tmr_on) begin
        if (ref_count != 0) begin m_tmr_on = 1'b1; m_next = cyc + int'(ref_count); end
      end else if (cyc == m_next) begin
        if (old_pend && !fin) e_miss = 1'b1;
        m_pend   = 1'b1;
        m_tmr_on = (ref_count != 0);
        m_next   = cyc + int'(ref_count);
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_output("model_req",       32'(bus.req),      32'(e_req));
    check_output("model_cmd",       32'(bus.cmd),      32'(e_cmd));
    check_output("model_cmd_addr",  32'(bus.cmd_addr), 32'(e_addr));
    check_output("model_init_done", 32'(init_done),    32'(e_done));
    check_output("model_ref_miss",  32'(ref_miss),     32'(e_miss));
  endtask

  task automatic apply_stimulus(input logic en, input logic g, input logic [2:0] rp,
                                input logic [2:0] rf, input logic [2:0] c, input logic [12:0] rc);
    ctrl_en = en; bus.gnt = g; t_rp = rp; t_ref = rf; cl = c; ref_count = rc;
  endtask

  task automatic wait_cmd(input logic [3:0] c, input int limit, input string name, output int n);
    n = 0;
    do begin step(); n++; end while (bus.cmd !== c && n < limit);
    if (bus.cmd !== c) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL %s: no cmd 0x%0h within %0d cycles, got 0x%0h", name, c, limit, bus.cmd);
      n = -1;
    end
  endtask

  task automatic wait_level(input bit use_done, input logic level, input int limit,
                            input string name, output int n);
    logic v;
    n = 0;
    do begin step(); n++; v = use_done ? init_done : bus.req; end while (v !== level && n < limit);
    if (v !== level) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL %s: level %0b not reached within %0d cycles, got %0b", name, level, limit, v);
      n = -1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0; step(); rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, pres;
    int rise[3];

    vecs[0] = '{rp:3'd2, rf:3'd3, c:3'd3, exp_first:INIT_WAIT+2, exp_pre_ar:3, exp_ar_ar:4, exp_ar_mrs:4, exp_done_lat:2, exp_mode_addr:13'h030};
    vecs[1] = '{rp:3'd0, rf:3'd0, c:3'd2, exp_first:INIT_WAIT+2, exp_pre_ar:2, exp_ar_ar:2, exp_ar_mrs:2, exp_done_lat:2, exp_mode_addr:13'h020};
    vecs[2] = '{rp:3'd7, rf:3'd1, c:3'd7, exp_first:INIT_WAIT+2, exp_pre_ar:8, exp_ar_ar:2, exp_ar_mrs:2, exp_done_lat:2, exp_mode_addr:13'h070};
    vecs[3] = '{rp:3'd1, rf:3'd5, c:3'd1, exp_first:INIT_WAIT+2, exp_pre_ar:2, exp_ar_ar:6, exp_ar_mrs:6, exp_done_lat:2, exp_mode_addr:13'h010};

    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 3'd2, 3'd3, 3'd3, 13'd0);
    for (int i = 0; i < 3; i++) step();
    check_output("rst_req",       32'(bus.req),      32'd0);
    check_output("rst_cmd",       32'(bus.cmd),      32'(NOP));
    check_output("rst_cmd_addr",  32'(bus.cmd_addr), 32'd0);
    check_output("rst_init_done", 32'(init_done),    32'd0);
    check_output("rst_ref_miss",  32'(ref_miss),     32'd0);
    rst = 1'b1;
    step();
    check_output("pwr_wait_req", 32'(bus.req), 32'd1);

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(1'b1, 1'b1, vecs[v].rp, vecs[v].rf, vecs[v].c, 13'd0);
      pulse_reset();
      wait_cmd(PRE, 60, "init_pre", n);
      check_output("init_first_cmd_delay", 32'(n), 32'(vecs[v].exp_first));
      check_output("init_pre_addr", 32'(bus.cmd_addr), 32'h400);
      wait_cmd(AR, 20, "init_ar1", n);
      check_output("init_pre_ar_spacing", 32'(n), 32'(vecs[v].exp_pre_ar));
      wait_cmd(AR, 20, "init_ar2", n);
      check_output("init_ar_ar_spacing", 32'(n), 32'(vecs[v].exp_ar_ar));
      wait_cmd(LMR, 20, "init_lmr", n);
      check_output("init_ar_mrs_spacing", 32'(n), 32'(vecs[v].exp_ar_mrs));
      check_output("init_mode_addr", 32'(bus.cmd_addr), 32'(vecs[v].exp_mode_addr));
      wait_level(1'b1, 1'b1, 10, "init_done_rise", n);
      check_output("init_done_latency", 32'(n), 32'(vecs[v].exp_done_lat));
      check_output("init_req_low", 32'(bus.req), 32'd0);
    end

    apply_stimulus(1'b1, 1'b1, 3'd2, 3'd3, 3'd3, 13'd50);
    pulse_reset();
    wait_level(1'b1, 1'b1, 100, "per_init", n);
    for (int k = 0; k < 3; k++) begin
      wait_level(1'b0, 1'b1, 120, "per_req_rise", n);
      rise[k] = cyc;
      if (k > 0) check_output("per_period", 32'(rise[k] - rise[k-1]), 32'd50);
      wait_cmd(PRE, 5, "per_pre", n);
      check_output("per_req_to_pre", 32'(n), 32'd1);
      wait_cmd(AR, 10, "per_ar", n);
      check_output("per_pre_to_ar", 32'(n), 32'd3);
      wait_level(1'b0, 1'b0, 10, "per_req_fall", n);
      check_output("per_ar_to_req_fall", 32'(n), 32'd3);
    end

    bus.gnt = 1'b0;
    wait_level(1'b0, 1'b1, 120, "hold_req_rise", n);
    for (int i = 0; i < 7; i++) begin
      step();
      check_output("hold_cmd_nop", 32'(bus.cmd), 32'(NOP));
      check_output("hold_req_high", 32'(bus.req), 32'd1);
    end
    bus.gnt = 1'b1;
    step();
    check_output("hold_pre_after_gnt", 32'(bus.cmd), 32'(PRE));
    wait_level(1'b0, 1'b0, 20, "hold_req_fall", n);
    check_output("hold_no_miss", 32'(ref_miss), 32'd0);

    apply_stimulus(1'b1, 1'b1, 3'd2, 3'd7, 3'd3, 13'd8);
    pulse_reset();
    wait_level(1'b1, 1'b1, 100, "miss_init", n);
    bus.gnt = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_output("miss_set", 32'(ref_miss), 32'd1);
    bus.gnt = 1'b1;
    pres = 0;
    n = 0;
    do begin
      step(); n++;
      if (bus.cmd === PRE) pres++;
    end while (bus.req !== 1'b0 && n < 60);
    check_output("miss_single_refresh", 32'(pres), 32'd1);
    for (int i = 0; i < 3; i++) step();
    check_output("miss_sticky", 32'(ref_miss), 32'd1);

    apply_stimulus(1'b1, 1'b1, 3'd2, 3'd3, 3'd3, 13'd0);
    pulse_reset();
    wait_cmd(PRE, 60, "drop_pre", n);
    wait_cmd(AR, 20, "drop_ar1", n);
    ctrl_en = 1'b0;
    step();
    check_output("drop_cmd_nop", 32'(bus.cmd), 32'(NOP));
    check_output("drop_req_low", 32'(bus.req), 32'd0);
    check_output("drop_init_done_low", 32'(init_done), 32'd0);
    ctrl_en = 1'b1;
    wait_cmd(PRE, 60, "drop_restart_pre", n);
    check_output("drop_restart_delay", 32'(n), 32'(INIT_WAIT + 2));

    for (int s = 0; s < 20; s++) begin
      apply_stimulus(1'b1, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom_range(8, 60)));
      if (s % 4 == 0) pulse_reset();
      for (int i = 0; i < 150; i++) begin
        bus.gnt = ($urandom_range(0, 9) < 7);
        ctrl_en = ($urandom_range(0, 299) != 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_ctrl_init_ref.md
# sdram_ctrl_init_ref

Power-up initialisation and periodic refresh sequencer for the i2d SDRAM controller. Consumes the timing/configuration fields held by the SDRAM controller register block (`ctrl_en`, `cl`, `t_rp`, `t_ref`, `ref_count`) and drives SDRAM commands onto the controller's command mux whenever the access engine grants it the bus. It owns the JEDEC init sequence (PRECHARGE ALL, 2× AUTO REFRESH, LOAD MODE) and the refresh interval timer.

## Interface
- `INIT_WAIT`, 20000, power-up idle cycles before the first command (200 µs at 100 MHz).
- `T_MRD`, 2, NOP cycles after LOAD MODE before `init_done` rises.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `ctrl_en` in 1: controller enable from register block; low aborts everything.
- `cl` in 3: CAS latency written into the mode register.
- `t_rp` in 3: precharge-to-command NOP cycles (0 treated as 1).
- `t_ref` in 3: refresh-to-command NOP cycles, i.e. tRFC (0 treated as 1).
- `ref_count` in 13: refresh interval in clk cycles; 0 disables periodic refresh.
- `gnt` in 1: access engine grants the command bus to this block.
- `req` out 1: bus request.
- `cmd` out 4: {cs_n, ras_n, cas_n, we_n}; NOP=0111, PRECHARGE=0010, AUTO_REFRESH=0001, LOAD_MODE=0000.
- `cmd_addr` out 13: SDRAM address bus for this block's commands.
- `init_done` out 1: init sequence complete; normal accesses allowed.
- `ref_miss` out 1: sticky; an interval expired while a refresh was still pending.

## Operation
- States: IDLE, PWR_WAIT, PRE, PRE_W, AR1, AR1_W, AR2, AR2_W, MRS, MRS_W, RUN, R_PRE, R_PRE_W, R_AR, R_AR_W.
- IDLE: entered on reset or when `ctrl_en`=0; all outputs at reset values. Goes to PWR_WAIT when `ctrl_en`=1.
- PWR_WAIT: counts `INIT_WAIT` cycles. `req`=1 from this state until `init_done` rises.
- Command states (PRE, AR1, AR2, MRS, R_PRE, R_AR): if `gnt`=0, hold state and drive NOP. If `gnt`=1, issue the command for exactly one cycle, load the wait counter, and move to the matching _W state.
- Waits: PRE_W/R_PRE_W last max(`t_rp`,1) NOP cycles; AR*_W/R_AR_W last max(`t_ref`,1) NOP cycles; MRS_W lasts `T_MRD` NOP cycles.
- `cmd_addr`: for PRECHARGE it is 13'h0400 (A10=1, all banks). For LOAD_MODE it is {3'b000, 1'b0, 2'b00, `cl`, 1'b0, 3'b000} (burst length 1, sequential, programmed burst write). Otherwise 0.
- MRS_W exit: `init_done`←1, `req`←0, go to RUN. The interval counter is loaded with `ref_count`.
- RUN: when `ref_count`≠0, the 13-bit counter decrements each cycle. On reaching 1 it reloads `ref_count` and sets `pending`. A new `ref_count` value takes effect only at the next reload or at RUN entry.
- `pending`=1 in RUN: `req`=1, go to R_PRE. After R_AR_W completes, clear `pending`, set `req`=0, return to RUN. The interval counter keeps running during the refresh sequence.
- Expiry with `pending` already 1: `ref_miss`←1 (sticky until reset or `ctrl_en`=0); `pending` remains 1, and no second refresh is queued.
- `ctrl_en`=0 in any state, mid-command included: the next state is IDLE; `cmd` becomes NOP and `req`, `init_done` and `pending` go to 0 on that edge. Re-enabling reruns the full init.

## Timing
- All outputs are registered. Reset values: `req`=0, `cmd`=4'b0111, `cmd_addr`=0, `init_done`=0, `ref_miss`=0.
- A command is driven in the cycle after the edge where its state was sampled with `gnt`=1. It is driven for exactly 1 cycle.
- Spacing between command cycles is N+1 clocks, where N is the wait length; for example `t_rp`=2 gives PRE at cycle c and AR at c+3 when `gnt` stays high.
- Refresh period in RUN is exactly `ref_count` cycles between `pending` sets, independent of `gnt` latency.
- `gnt` may be asserted in any cycle. It is ignored outside command states, and `req` is not deasserted while waiting for it.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `ctrl_en`=1 → all outputs at reset values; after release, PWR_WAIT starts.
- Full init (`INIT_WAIT`=10, `t_rp`=2, `t_ref`=3, `cl`=3, `gnt`=1) → PRE with addr 0x400, then AR, AR, then LOAD_MODE with addr 0x030. Command spacings are 3, 4 and 4 cycles; `init_done` rises 2 cycles after LOAD_MODE.
- Periodic refresh (`ref_count`=50) → `req` rises every 50 cycles, followed by PRE, then AR 3 cycles later, then `req` falls after the tRFC wait.
- `gnt` withheld 7 cycles in R_PRE → `cmd` stays NOP and `req` stays high; PRE is issued the cycle after `gnt` rises.
- `ref_count`=8, `t_ref`=7, `gnt` held low 20 cycles → `ref_miss`=1 and stays 1; only one refresh is issued when `gnt` returns.
- `ctrl_en` dropped during AR1_W → next cycle: `cmd`=NOP, `req`=0, `init_done`=0; re-raising `ctrl_en` restarts PWR_WAIT from 0.
